// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI register-access arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int unsigned RW_BIT     = 7;
    localparam logic [7:0]  DUMMY_BYTE = 8'h00;

    // Address byte on the wire: bit 7 set means read.
    function automatic logic [7:0] addr_byte(input logic we, input logic [6:0] addr);
        logic [7:0] b;
        b         = {1'b0, addr};
        b[RW_BIT] = ~we;
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; pointer advances only when update_i is set.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    update_i,
    output logic                    any_c,
    output logic [$clog2(NREQ)-1:0] grant_idx_c
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        any_c       = 1'b0;
        grant_idx_c = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (!any_c && req_i[IW'((int'(last_q) + i) % int'(NREQ))]) begin
                any_c       = 1'b1;
                grant_idx_c = IW'((int'(last_q) + i) % int'(NREQ));
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (update_i && any_c) begin
            last_d = grant_idx_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Shares one spi_master between NREQ register-access requesters (round-robin).
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_reg_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned MAX_BYTES      = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NREQ-1:0]                        req_i,
    input  logic [NREQ-1:0]                        we_i,
    input  logic [NREQ*7-1:0]                      addr_i,
    input  logic [NREQ*8-1:0]                      wdata_i,
    input  logic [NREQ*($clog2(MAX_BYTES)+1)-1:0]  len_i,
    output logic [NREQ-1:0]                        ack_o,
    output logic [NREQ-1:0]                        done_o,
    output logic [NREQ-1:0]                        err_o,
    output logic                                   rd_valid_o,
    output logic [7:0]                             rd_data_o,
    output logic [$clog2(MAX_BYTES):0]             rd_idx_o,
    output logic [$clog2(NREQ)-1:0]                rd_owner_o,
    output logic                                   m_start_o,
    output logic [7:0]                             m_tx_data_o,
    output logic [$clog2(MAX_BYTES):0]             m_n_bytes_o,
    output logic [7:0]                             m_next_tx_o,
    input  logic                                   m_busy_i,
    input  logic                                   m_done_i,
    input  logic                                   m_req_next_i,
    input  logic                                   m_rx_valid_i,
    input  logic [7:0]                             m_rx_data_i,
    input  logic [$clog2(MAX_BYTES):0]             m_rx_idx_i
);

    localparam int unsigned LW = $clog2(MAX_BYTES) + 1;
    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e          state_q,     state_d;
    logic [OW-1:0]   owner_q,     owner_d;
    logic            we_q,        we_d;
    logic [6:0]      addr_q,      addr_d;
    logic [LW-1:0]   len_q,       len_d;
    logic [GW-1:0]   gap_q,       gap_d;
    logic [NREQ-1:0] ack_q,       ack_d;
    logic [NREQ-1:0] done_q,      done_d;
    logic [NREQ-1:0] err_q,       err_d;
    logic            rd_valid_q,  rd_valid_d;
    logic [7:0]      rd_data_q,   rd_data_d;
    logic [LW-1:0]   rd_idx_q,    rd_idx_d;
    logic [OW-1:0]   rd_owner_q,  rd_owner_d;
    logic            m_start_q,   m_start_d;
    logic [7:0]      m_tx_data_q, m_tx_data_d;
    logic [LW-1:0]   m_n_bytes_q, m_n_bytes_d;
    logic [7:0]      m_next_tx_q, m_next_tx_d;

    logic            gnt_any_c;
    logic [OW-1:0]   gnt_idx_c;
    logic            gnt_upd_c;
    logic            we_sel_c;
    logic [6:0]      addr_sel_c;
    logic [7:0]      wdata_sel_c;
    logic [LW-1:0]   len_sel_c;
    logic            illegal_c;
    logic            timeout_c;
    logic            unused_c;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .update_i    (gnt_upd_c),
        .any_c       (gnt_any_c),
        .grant_idx_c (gnt_idx_c)
    );

    assign we_sel_c    = we_i[gnt_idx_c];
    assign addr_sel_c  = addr_i[int'(gnt_idx_c)*7 +: 7];
    assign wdata_sel_c = wdata_i[int'(gnt_idx_c)*8 +: 8];
    assign len_sel_c   = len_i[int'(gnt_idx_c)*int'(LW) +: LW];
    assign illegal_c   = !we_sel_c && ((len_sel_c == '0) || (32'(len_sel_c) >= MAX_BYTES));

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] to_q, to_d;

    // Counts cycles spent in WAIT; cleared everywhere else.
    always_comb begin
        to_d = '0;
        if (state_q == ST_WAIT) begin
            to_d = to_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end

    assign timeout_c = (to_q == TW'(TIMEOUT_CYCLES - 1));
    assign unused_c  = m_req_next_i;
`else
    assign timeout_c = 1'b0;
    assign unused_c  = ^{m_req_next_i, 32'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        len_d       = len_q;
        gap_d       = gap_q;
        ack_d       = '0;
        done_d      = '0;
        err_d       = '0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_idx_d    = rd_idx_q;
        rd_owner_d  = rd_owner_q;
        m_start_d   = 1'b0;
        m_tx_data_d = m_tx_data_q;
        m_n_bytes_d = m_n_bytes_q;
        m_next_tx_d = m_next_tx_q;
        gnt_upd_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any_c && !m_busy_i) begin
                    gnt_upd_c            = 1'b1;
                    owner_d              = gnt_idx_c;
                    we_d                 = we_sel_c;
                    addr_d               = addr_sel_c;
                    len_d                = len_sel_c;
                    m_next_tx_d          = we_sel_c ? wdata_sel_c : DUMMY_BYTE;
                    ack_d[gnt_idx_c]     = 1'b1;
                    // Bad read length is answered with an error, never reaching the wire.
                    if (illegal_c) begin
                        done_d[gnt_idx_c] = 1'b1;
                        err_d[gnt_idx_c]  = 1'b1;
                        gap_d             = GW'(GAP_CYCLES);
                        state_d           = ST_GAP;
                    end else begin
                        state_d           = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                m_start_d   = 1'b1;
                m_tx_data_d = addr_byte(we_q, addr_q);
                m_n_bytes_d = we_q ? LW'(2) : (len_q + LW'(1));
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Byte 0 is the address phase; writes return nothing useful.
                if (m_rx_valid_i && !we_q && (m_rx_idx_i != '0)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = m_rx_data_i;
                    rd_idx_d   = m_rx_idx_i - LW'(1);
                    rd_owner_d = owner_q;
                end
                if (m_done_i) begin
                    done_d[owner_q] = 1'b1;
                    gap_d           = GW'(GAP_CYCLES);
                    state_d         = ST_GAP;
                end else if (timeout_c) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    gap_d           = GW'(GAP_CYCLES);
                    state_d         = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_idx_q    <= '0;
            rd_owner_q  <= '0;
            m_start_q   <= 1'b0;
            m_tx_data_q <= '0;
            m_n_bytes_q <= '0;
            m_next_tx_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_idx_q    <= rd_idx_d;
            rd_owner_q  <= rd_owner_d;
            m_start_q   <= m_start_d;
            m_tx_data_q <= m_tx_data_d;
            m_n_bytes_q <= m_n_bytes_d;
            m_next_tx_q <= m_next_tx_d;
        end
    end

    assign ack_o       = ack_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_idx_o    = rd_idx_q;
    assign rd_owner_o  = rd_owner_q;
    assign m_start_o   = m_start_q;
    assign m_tx_data_o = m_tx_data_q;
    assign m_n_bytes_o = m_n_bytes_q;
    assign m_next_tx_o = m_next_tx_q;

endmodule

// File: doc/spi_reg_arbiter.md
# spi_reg_arbiter

Register-access scheduler in front of `spi_master` for the ICM-42688-P link. It shares one SPI master between `NREQ` requesters, such as init/config and periodic sensor burst read, using round-robin arbitration. For each granted request it builds the transaction (address byte with R/W flag, write data or dummy bytes) and streams TX bytes on demand. Received read data goes back to the owner, tagged with a byte index.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..4).
- `MAX_BYTES`, 16: must equal the `spi_master` `MAX_BYTES`; max read length is `MAX_BYTES-1`.
- `GAP_CYCLES`, 4: minimum `clk_i` cycles between `m_done_i` and the next `m_start_o`, for CS-high time.
- `TIMEOUT_CYCLES`, 65535: watchdog limit; used only with `SPI_ARB_TIMEOUT_EN`.

Ports (`LW = $clog2(MAX_BYTES)+1`):
- `clk_i` in 1: system clock. Single clock domain.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in `NREQ`: request, level, held until `ack_o`.
- `we_i` in `NREQ`: 1 = write, 0 = read.
- `addr_i` in `NREQ*7`: register address, requester k at `[7k+:7]`.
- `wdata_i` in `NREQ*8`: write byte.
- `len_i` in `NREQ*LW`: read length in data bytes; ignored for writes.
- `ack_o` out `NREQ`: 1-cycle pulse; request latched.
- `done_o` out `NREQ`: 1-cycle pulse; transaction finished.
- `err_o` out `NREQ`: 1-cycle pulse coincident with `done_o` on error.
- `rd_valid_o` out 1: read data byte valid, 1-cycle pulse.
- `rd_data_o` out 8: read data byte.
- `rd_idx_o` out `LW`: data byte index, 0-based, excluding the address byte.
- `rd_owner_o` out `$clog2(NREQ)`: requester owning `rd_*`.
- `m_start_o` out 1: start pulse to `spi_master`.
- `m_tx_data_o` out 8: first byte.
- `m_n_bytes_o` out `LW`: byte count.
- `m_next_tx_o` out 8: next TX byte.
- `m_busy_i` in 1: master busy.
- `m_done_i` in 1: master done pulse.
- `m_req_next_i` in 1: master next-byte request.
- `m_rx_valid_i` in 1: master RX byte valid.
- `m_rx_data_i` in 8: master RX byte.
- `m_rx_idx_i` in `LW`: master RX byte index.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `GAP`.
- `IDLE`:
  - If any `req_i` is set and `m_busy_i`=0, pick the winner round-robin, searching from `last_grant+1` modulo `NREQ`.
  - Latch `we`, `addr`, `wdata`, `len`; pulse `ack_o[w]`; go to `ISSUE`.
- Illegal read: `len`=0 or `len > MAX_BYTES-1`.
  - Go to `GAP`, pulsing `done_o[w]` and `err_o[w]` in the next cycle.
  - No SPI activity. `last_grant` is still updated.
- `ISSUE`: pulse `m_start_o` with:
  - `m_tx_data_o = {~we, addr}`;
  - `m_n_bytes_o` = 2 for a write, `1+len` for a read.
  - Then go to `WAIT`.
- `WAIT`:
  - `m_next_tx_o` is held combinationally: `wdata` for a write, 0x00 for a read. It is valid whenever `m_req_next_i` may rise.
  - Read data forwarding: `m_rx_valid_i` with `m_rx_idx_i` ≥ 1 gives `rd_valid_o`=1, `rd_data_o`=`m_rx_data_i`, `rd_idx_o = m_rx_idx_i-1`, `rd_owner_o` = owner, registered (1-cycle latency).
  - Index 0 (address phase) and all bytes of a write are dropped.
  - On `m_done_i`: pulse `done_o[owner]` next cycle, load the gap counter, go to `GAP`.
- `GAP`: count down `GAP_CYCLES`, then return to `IDLE`. Requests are not sampled during `GAP`.
- `req_i` deasserted before `ack_o`: the request is withdrawn and never serviced.
- A requester may re-request in the cycle after `ack_o`; it is queued for the next arbitration.

## Timing
- `req` to `ack_o`: 1 cycle when idle.
- `ack_o` to `m_start_o`: 1 cycle.
- `m_done_i` to `done_o`: 1 cycle.
- Start-to-start spacing is at least `GAP_CYCLES`+2 cycles after `m_done_i`.
- Reset value of every output is 0; `last_grant` resets to `NREQ-1`, so requester 0 wins first.
- Reset mid-transaction:
  - Outputs clear immediately and the state returns to `IDLE`.
  - `spi_master` shares the system reset, so it aborts as well.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in `WAIT`.
  - If `TIMEOUT_CYCLES` elapse without `m_done_i`, pulse `done_o` and `err_o` for the owner and go to `GAP`.
  - A later stray `m_done_i` is ignored outside `WAIT`.
  - In `IDLE`, arbitration additionally waits for `m_busy_i`=0, as always.
- Not defined: no counter; `WAIT` waits indefinitely, and `err_o` reports only illegal length.

## Structure
- Package `spi_arb_pkg` holds:
  - state enum constants;
  - the R/W flag position (bit 7, 1 = read);
  - the 0x00 dummy byte.
- Sub-module `rr_arbiter` (`NREQ`-wide round-robin grant with pointer update enable) is natural. Everything else stays in one module.

## Test plan
- Write: req0 with `we`=1, addr 0x4E, wdata 0x0F:
  - `m_start_o` with tx 0x4E, n=2;
  - `m_next_tx_o`=0x0F at `m_req_next_i`;
  - `done_o[0]` one cycle after `m_done_i`; no `rd_valid_o`.
- Burst read: req1 with `we`=0, addr 0x1D, len 12:
  - tx 0x9D, n=13;
  - twelve `rd_valid_o` with idx 0..11, owner 1, data matching the SPI model.
- Contention: req0 and req1 held continuously:
  - grants alternate 0, 1, 0, 1;
  - each `m_start_o` at least `GAP_CYCLES`+2 cycles after the previous `m_done_i`.
- Illegal read: req0 read with len 0, then len 16:
  - `done_o[0]` and `err_o[0]` each time;
  - `m_start_o` never pulses.
- Reset mid-read: assert `rst_i` during byte 3:
  - all outputs 0 in the same cycle;
  - after release, a pending req1 with req0 idle → grant 1.
- With `SPI_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, withhold `m_done_i`:
  - `done_o` and `err_o` for the owner after 100 cycles in `WAIT`;
  - the arbiter recovers to `IDLE`.
